// File: rtl/vcfg_unit.sv
// vcfg_unit: vector configuration unit for vsetvli / vsetivli / vsetvl.
// A request is captured in IDLE. The new vtype and vl are worked out in CALC
// and committed on the move to RESP. The response holds until the consumer
// accepts it.
module vcfg_unit #(
    parameter int         VLEN   = 4096,
    parameter int         ELEN   = 64,
    parameter logic [2:0] MaxLut = 3'b101
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [1:0]                 req_kind_i,
    input  logic                       req_rd_zero_i,
    input  logic                       req_rs1_zero_i,
    input  logic [63:0]                req_avl_i,
    input  logic [63:0]                req_vtype_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [63:0]                resp_vl_o,
    output logic [12:0]                vtype_o,
    output logic [$clog2(VLEN):0]      vl_o,
    output logic [3:0]                 hist_tag_o
);

    localparam int          VLW        = $clog2(VLEN) + 1;
    localparam logic [2:0]  LMUL_RSVD  = 3'b100;
    localparam logic        VREUSE_ON  = 1'b1;
    localparam logic [12:0] VTYPE_VILL = 13'h1000;
    localparam logic [1:0]  KIND_VSETIVLI = 2'd1;
    localparam logic [1:0]  KIND_RSVD     = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            resp_valid_q, resp_valid_d;
    logic [63:0]     resp_vl_q, resp_vl_d;
    logic [12:0]     vtype_q, vtype_d;
    logic [VLW-1:0]  vl_q, vl_d;
    logic [3:0]      tag_q, tag_d;

    // Captured request fields. These are data only and carry no reset.
    logic [1:0]      kind_q, kind_d;
    logic            rd_zero_q, rd_zero_d;
    logic            rs1_zero_q, rs1_zero_d;
    logic [63:0]     avl_q, avl_d;
    logic [63:0]     raw_q, raw_d;

    // Values worked out from the captured request.
    logic [2:0]      vlmul;
    logic [2:0]      vsew;
    logic [2:0]      vlut;
    logic [31:0]     sew_bits;
    logic [3:0]      frac_sh;
    logic [3:0]      sew_sh;
    logic            illegal;
    logic [63:0]     vlmax_base;
    logic [63:0]     vlmax;
    logic [63:0]     avl_sel;
    logic [63:0]     min_vl;
    logic [VLW-1:0]  new_vl;
    logic            tag_hold;

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_vl_o    = resp_vl_q;
    assign vtype_o      = vtype_q;
    assign vl_o         = vl_q;
    assign hist_tag_o   = tag_q;

    // Check legality, compute VLMAX and the AVL to use, then clamp vl to VLMAX.
    always_comb begin
        vlmul    = raw_q[2:0];
        vsew     = raw_q[5:3];
        vlut     = raw_q[10:8];
        sew_bits = 32'd8 << vsew;
        // Fractional encodings 5, 6, 7 mean 1/8, 1/4, 1/2, which is a right shift by 8 - vlmul.
        frac_sh  = 4'd8 - {1'b0, vlmul};
        sew_sh   = {1'b0, vsew} + 4'd3;

        illegal = 1'b0;
        if (vlmul == LMUL_RSVD)                                  illegal = 1'b1;
        if (sew_bits > 32'(ELEN))                                illegal = 1'b1;
        if (vlmul[2] && ((sew_bits << frac_sh) > 32'(ELEN)))     illegal = 1'b1;
        if (vlut > MaxLut)                                       illegal = 1'b1;
        if (|raw_q[63:12])                                       illegal = 1'b1;
        if (kind_q == KIND_RSVD)                                 illegal = 1'b1;

        vlmax_base = 64'(VLEN) >> sew_sh;
        if (vlmul[2]) begin
            vlmax = vlmax_base >> frac_sh;
        end else begin
            vlmax = vlmax_base << vlmul[1:0];
        end

        if (kind_q == KIND_VSETIVLI) begin
            avl_sel = avl_q;
        end else if (rs1_zero_q && !rd_zero_q) begin
            avl_sel = vlmax;
        end else if (rs1_zero_q && rd_zero_q) begin
            avl_sel = 64'(vl_q);
        end else begin
            avl_sel = avl_q;
        end

        // The comparison uses the full 64 bits, so a large AVL cannot alias to a small vl.
        min_vl = (avl_sel < vlmax) ? avl_sel : vlmax;
        new_vl = illegal ? '0 : min_vl[VLW-1:0];

        // The LUT history stays only when reuse is asked for with the same LUT on top of a valid vtype.
        tag_hold = (raw_q[11] == VREUSE_ON) && (vlut == vtype_q[10:8]) && !vtype_q[12];
    end

    // Next-state logic for the handshake FSM and the committed configuration.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_vl_d    = resp_vl_q;
        vtype_d      = vtype_q;
        vl_d         = vl_q;
        tag_d        = tag_q;
        kind_d       = kind_q;
        rd_zero_d    = rd_zero_q;
        rs1_zero_d   = rs1_zero_q;
        avl_d        = avl_q;
        raw_d        = raw_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    kind_d     = req_kind_i;
                    rd_zero_d  = req_rd_zero_i;
                    rs1_zero_d = req_rs1_zero_i;
                    avl_d      = req_avl_i;
                    raw_d      = req_vtype_i;
                    state_d    = CALC;
                end
            end
            CALC: begin
                vl_d         = new_vl;
                resp_vl_d    = {{(64-VLW){1'b0}}, new_vl};
                resp_valid_d = 1'b1;
                state_d      = RESP;
                if (illegal) begin
                    vtype_d = VTYPE_VILL;
                end else begin
                    vtype_d = {1'b0, raw_q[11:0]};
                    if (!tag_hold) begin
                        tag_d = tag_q + 4'd1;
                    end
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and committed state. Reset discards any request that is in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_vl_q    <= '0;
            vtype_q      <= VTYPE_VILL;
            vl_q         <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_vl_q    <= resp_vl_d;
            vtype_q      <= vtype_d;
            vl_q         <= vl_d;
            tag_q        <= tag_d;
        end
    end

    // Request capture registers. They are only read after a capture, so they need no reset.
    always_ff @(posedge clk_i) begin
        kind_q     <= kind_d;
        rd_zero_q  <= rd_zero_d;
        rs1_zero_q <= rs1_zero_d;
        avl_q      <= avl_d;
        raw_q      <= raw_d;
    end

endmodule

// File: tb/tb_vcfg_unit.sv
// Directed testbench for vcfg_unit with VLEN=4096 and ELEN=64.
module tb_vcfg_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_kind_i;
    logic        req_rd_zero_i;
    logic        req_rs1_zero_i;
    logic [63:0] req_avl_i;
    logic [63:0] req_vtype_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_vl_o;
    logic [12:0] vtype_o;
    logic [12:0] vl_o;
    logic [3:0]  hist_tag_o;

    int checks = 0;
    int passed = 0;

    vcfg_unit #(.VLEN(4096), .ELEN(64), .MaxLut(3'b101)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_kind_i     (req_kind_i),
        .req_rd_zero_i  (req_rd_zero_i),
        .req_rs1_zero_i (req_rs1_zero_i),
        .req_avl_i      (req_avl_i),
        .req_vtype_i    (req_vtype_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_vl_o      (resp_vl_o),
        .vtype_o        (vtype_o),
        .vl_o           (vl_o),
        .hist_tag_o     (hist_tag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one request from IDLE and advance to the cycle where the response should appear.
    task automatic send(input logic [1:0] kind, input logic rdz, input logic rs1z,
                        input logic [63:0] avl, input logic [63:0] vt);
        chk("ready_before_send", 64'(req_ready_o), 64'd1);
        req_valid_i    = 1'b1;
        req_kind_i     = kind;
        req_rd_zero_i  = rdz;
        req_rs1_zero_i = rs1z;
        req_avl_i      = avl;
        req_vtype_i    = vt;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("no_resp_in_calc", 64'(resp_valid_o), 64'd0);
        @(posedge clk_i); #1;
        chk("resp_at_n_plus_2", 64'(resp_valid_o), 64'd1);
    endtask

    // Accept the pending response, then confirm the unit is back in IDLE.
    task automatic take_resp();
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        chk("resp_cleared", 64'(resp_valid_o), 64'd0);
    endtask

    task automatic expect_cfg(input string tag, input logic [12:0] vt, input logic [12:0] vl,
                              input logic [3:0] tg);
        chk({tag, "_vtype"}, 64'(vtype_o), 64'(vt));
        chk({tag, "_vl"}, 64'(vl_o), 64'(vl));
        chk({tag, "_resp_vl"}, resp_vl_o, 64'(vl));
        chk({tag, "_tag"}, 64'(hist_tag_o), 64'(tg));
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_kind_i = 2'd0; req_rd_zero_i = 1'b0;
        req_rs1_zero_i = 1'b0; req_avl_i = '0; req_vtype_i = '0; resp_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state
        chk("rst_vtype", 64'(vtype_o), 64'h1000);
        chk("rst_vl", 64'(vl_o), 64'd0);
        chk("rst_tag", 64'(hist_tag_o), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_resp_vl", resp_vl_o, 64'd0);

        // vsetvli AVL=1000 SEW32 LMUL2 gives VLMAX 256
        send(2'd0, 1'b0, 1'b0, 64'd1000, 64'h011);
        expect_cfg("sew32_m2", 13'h011, 13'd256, 4'd1);
        take_resp();

        // rs1=x0 with rd!=x0 selects VLMAX: SEW8 LMUL8 gives 4096
        send(2'd0, 1'b0, 1'b1, 64'd3, 64'h003);
        expect_cfg("vlmax_sel", 13'h003, 13'd4096, 4'd2);
        take_resp();

        // rs1=x0 with rd=x0 keeps the current vl (4096), clamped to SEW64 LMUL1 VLMAX of 64
        send(2'd0, 1'b1, 1'b1, 64'd0, 64'h018);
        expect_cfg("keep_vl", 13'h018, 13'd64, 4'd3);
        take_resp();

        // Illegal cases leave the tag untouched
        send(2'd0, 1'b0, 1'b0, 64'd10, 64'h01D);
        expect_cfg("ill_sew64_mf8", 13'h1000, 13'd0, 4'd3);
        take_resp();
        send(2'd0, 1'b0, 1'b0, 64'd10, 64'h600);
        expect_cfg("ill_vlut6", 13'h1000, 13'd0, 4'd3);
        take_resp();
        send(2'd3, 1'b0, 1'b0, 64'd10, 64'h000);
        expect_cfg("ill_kind3", 13'h1000, 13'd0, 4'd3);
        take_resp();
        send(2'd2, 1'b0, 1'b0, 64'd10, 64'h1000);
        expect_cfg("ill_rsvd_bits", 13'h1000, 13'd0, 4'd3);
        take_resp();

        // A large AVL must compare at full width: SEW8 LMUL1 VLMAX is 512
        send(2'd0, 1'b0, 1'b0, 64'h1_0000_0005, 64'h000);
        expect_cfg("wide_avl", 13'h000, 13'd512, 4'd4);
        take_resp();

        // vsetivli uses the immediate even when rs1_zero is set
        send(2'd1, 1'b0, 1'b1, 64'd31, 64'h000);
        expect_cfg("vsetivli", 13'h000, 13'd31, 4'd5);
        take_resp();

        // LUT reuse: first config is new, the repeat with vreuse ON holds, the one with vreuse OFF bumps
        send(2'd0, 1'b0, 1'b0, 64'd5, 64'h300);
        expect_cfg("lut_first", 13'h300, 13'd5, 4'd6);
        take_resp();
        send(2'd0, 1'b0, 1'b0, 64'd5, 64'hB00);
        expect_cfg("lut_reuse", 13'hB00, 13'd5, 4'd6);
        take_resp();
        send(2'd0, 1'b0, 1'b0, 64'd5, 64'h300);
        expect_cfg("lut_off", 13'h300, 13'd5, 4'd7);
        take_resp();
        for (int i = 0; i < 16; i++) begin
            send(2'd0, 1'b0, 1'b0, 64'd5, 64'h300);
            take_resp();
        end
        chk("tag_wrap", 64'(hist_tag_o), 64'd7);

        // Fractional legal: SEW8 LMUL 1/8 gives VLMAX 64
        send(2'd0, 1'b0, 1'b1, 64'd0, 64'h005);
        expect_cfg("frac_mf8", 13'h005, 13'd64, 4'd8);
        take_resp();

        // Back-pressure: the response holds and a concurrent request is ignored
        send(2'd0, 1'b0, 1'b0, 64'd7, 64'h300);
        req_valid_i = 1'b1; req_kind_i = 2'd0; req_avl_i = 64'd99; req_vtype_i = 64'h011;
        req_rs1_zero_i = 1'b0; req_rd_zero_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("bp_valid", 64'(resp_valid_o), 64'd1);
            chk("bp_resp_vl", resp_vl_o, 64'd7);
            chk("bp_ready", 64'(req_ready_o), 64'd0);
        end
        req_valid_i = 1'b0;
        take_resp();
        chk("bp_vl_kept", 64'(vl_o), 64'd7);
        chk("bp_vtype_kept", 64'(vtype_o), 64'h300);
        chk("bp_tag", 64'(hist_tag_o), 64'd9);
        @(posedge clk_i); #1;
        chk("bp_no_second_resp", 64'(resp_valid_o), 64'd0);
        chk("bp_idle", 64'(req_ready_o), 64'd1);

        // Reset while in CALC discards the request
        req_valid_i = 1'b1; req_kind_i = 2'd0; req_avl_i = 64'd20; req_vtype_i = 64'h000;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("calc_rst_vtype", 64'(vtype_o), 64'h1000);
        chk("calc_rst_vl", 64'(vl_o), 64'd0);
        chk("calc_rst_tag", 64'(hist_tag_o), 64'd0);
        chk("calc_rst_valid", 64'(resp_valid_o), 64'd0);
        @(posedge clk_i); #1;
        chk("calc_rst_still_no_resp", 64'(resp_valid_o), 64'd0);

        // A legal config after reset bumps the tag from 0
        send(2'd0, 1'b0, 1'b0, 64'd1000, 64'h011);
        expect_cfg("post_rst", 13'h011, 13'd256, 4'd1);
        take_resp();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
